gray_histogram: RTL and testbench
=================================

Name: gray_histogram

Overview:
Downstream consumer of the RGB-to-grayscale stage. It accumulates a 256-bin histogram of 8-bit gray pixels over one frame, then streams the bins out over a valid/ready handshake for thresholding and contrast logic. Bin storage is a synchronous RAM, updated by a read-modify-write pipeline with forwarding. Bins clear automatically after readout.

Parameters:
PIX_W, 8, gray pixel width; the bin count is 2**PIX_W.
FRAME_PIXELS, 76800, pixels per frame (320x240).
CNT_W, 17, bin counter width; must satisfy 2**CNT_W > FRAME_PIXELS.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  single-cycle pulse that begins accumulation; honoured only in IDLE.
pix_valid  in  1  pix_data is valid this cycle.
pix_data  in  PIX_W  gray value (the RedOut/GreenOut/BlueOut value from the grayscale stage).
pix_ready  out  1  block accepts a pixel this cycle.
rd_valid  out  1  rd_bin/rd_count hold a valid bin.
rd_ready  in  1  downstream accepts the current bin.
rd_bin  out  PIX_W  bin index.
rd_count  out  CNT_W  pixel count for rd_bin.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear_idx=0, pix_cnt=0, pipeline valid bits=0. Output reset values: pix_ready=0, rd_valid=0, rd_bin=0, rd_count=0, busy=1.
- Reset mid-operation aborts the frame. The partial histogram is discarded and the full CLEAR pass is re-run.
- CLEAR: writes 0 to RAM[clear_idx] once per cycle, 256 cycles in total. After the write to index 255 the state moves to IDLE, so busy falls 256 cycles after reset release.
- IDLE: pix_ready=0, and pixels presented here are dropped. frame_start=1 moves the state to ACCUM on the next edge. A pixel presented in the same cycle as frame_start is not counted.
- ACCUM:
  - pix_ready = (pix_cnt < FRAME_PIXELS).
  - A pixel is accepted when pix_valid && pix_ready, and pix_cnt increments.
  - Stage 1 issues a RAM read at address pix_data.
  - Stage 2, one cycle later, writes read_data+1.
  - Forwarding: if the stage-2 address equals the address in flight, the just-computed value is used in place of the stale RAM data. Back-to-back identical pixels must count correctly.
  - No saturation logic is needed, because no count can exceed FRAME_PIXELS.
- Drain: if the last pixel is accepted at cycle T, its write occurs at T+1 and the state becomes READOUT at T+2.
- READOUT:
  - The read of bin 0 is issued on entry, and rd_valid=1 with rd_bin=0 at T+3.
  - On rd_valid && rd_ready the block advances to the next bin. The next bin's data is prefetched so that a continuously asserted rd_ready yields one bin per cycle.
  - While rd_ready=0, rd_bin and rd_count stay stable and rd_valid stays high.
  - Acceptance of bin 255 moves the state to CLEAR and drops rd_valid on the next edge.
- frame_start is ignored in CLEAR, ACCUM and READOUT.
- pix_valid is ignored outside ACCUM.
- Widths: the increment is CNT_W bits, and every RAM word is CNT_W bits.
- The RAM has one write port and one read port, synchronous read with 1-cycle latency. In CLEAR the write port is muxed to the clear logic.

Decomposition:
- Package gray_pkg holds:
  - localparams PIX_W=8 and NUM_BINS=256;
  - a state enum {CLEAR, IDLE, ACCUM, READOUT};
  - a CNT_W helper function (clog2(FRAME_PIXELS+1)).
- Sub-module hist_ram is a simple dual-port synchronous RAM, parameters DEPTH and WIDTH, with no reset on the array. The top level holds the FSM, the RMW pipeline, forwarding and readout prefetch.

Test Plan:
All scenarios use FRAME_PIXELS=8 and CNT_W=4.
- Release reset -> busy=1 for exactly 256 cycles, then IDLE. Then frame_start plus 8 consecutive pixels of 0x80 -> readout gives rd_count=8 at bin 128 and 0 at all other bins (exercises forwarding).
- Pixels 0,1,0,1,255,255,7,0 with pix_valid gapped 1-3 cycles -> bin0=3, bin1=2, bin7=1, bin255=2, others 0. First rd_valid falls exactly 3 cycles after the last pixel is accepted.
- Backpressure: rd_ready low for 5 cycles while rd_bin=3 -> rd_bin=3, rd_count and rd_valid stay unchanged. Continuous rd_ready -> 256 bins in 256 consecutive cycles.
- pix_valid asserted in IDLE with pix_ready=0, and frame_start pulsed during READOUT -> both ignored, and the histogram is unchanged.
- rst_n low for 1 cycle after 4 of 8 pixels (all 0x10) -> outputs return to reset values. A CLEAR pass follows, and a new frame of 8 pixels of 0x20 reads bin16=0 and bin32=8.
- Two back-to-back frames (8x0x05, then 8x0x06) -> second readout gives bin5=0 and bin6=8, proving the auto-clear.

Source files
------------

// File: rtl/gray_histogram_pkg.sv
// gray_pkg: shared definitions for the gray-level histogram block.
//   PIX_W    - gray pixel width
//   NUM_BINS - number of histogram bins (2**PIX_W)
//   state_e  - controller states
//   cnt_w()  - bin counter width needed to hold a full-frame count
package gray_pkg;

  localparam int PIX_W    = 8;
  localparam int NUM_BINS = 256;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    ACCUM   = 2'd2,
    READOUT = 2'd3
  } state_e;

  // Smallest width whose range covers 0..frame_pixels inclusive.
  function automatic int cnt_w(input int frame_pixels);
    return $clog2(frame_pixels + 32'sd1);
  endfunction

endpackage

// File: rtl/gray_histogram_if.sv
// gray_histogram_if: pixel input stream, bin readout stream and status.
//   frame_start - begin accumulation (pulse)
//   pix_valid / pix_data / pix_ready - gray pixel handshake
//   rd_valid / rd_ready / rd_bin / rd_count - bin readout handshake
//   busy - block not idle
// master = pixel producer / bin consumer, slave = histogram block.
interface gray_histogram_if
  import gray_pkg::*;
#(
  parameter int CNT_W = 17
) ();

  logic             frame_start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             rd_valid;
  logic             rd_ready;
  logic [PIX_W-1:0] rd_bin;
  logic [CNT_W-1:0] rd_count;
  logic             busy;

  modport master (
    output frame_start, pix_valid, pix_data, rd_ready,
    input  pix_ready, rd_valid, rd_bin, rd_count, busy
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, rd_ready,
    output pix_ready, rd_valid, rd_bin, rd_count, busy
  );

endinterface

// File: rtl/gray_histogram_hist_ram.sv
// hist_ram: simple dual-port synchronous RAM for histogram bins.
//   clk, rst_n     - clock, async active-low reset (read register only)
//   we/waddr/wdata - write port
//   raddr/rdata    - read port, 1-cycle latency, returns old data on a
//                    same-cycle write to the same address
// The storage array itself is never reset; it is cleared by the owner.
module hist_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {WIDTH{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/gray_histogram.sv
// gray_histogram: 256-bin histogram of a frame of gray pixels.
//   clk   - rising-edge clock
//   rst_n - async active-low reset
//   bus   - gray_histogram_if slave: frame_start, pixel stream in,
//           bin stream out (rd_bin/rd_count), busy status
// Flow: CLEAR (zero all bins) -> IDLE -> ACCUM (read-modify-write per
// pixel, with forwarding) -> READOUT (one bin per cycle) -> CLEAR.
module gray_histogram
  import gray_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = cnt_w(FRAME_PIXELS)
) (
  input logic              clk,
  input logic              rst_n,
  gray_histogram_if.slave  bus
);

  localparam logic [1:0]       S_CLEAR   = CLEAR;
  localparam logic [1:0]       S_IDLE    = IDLE;
  localparam logic [1:0]       S_ACCUM   = ACCUM;
  localparam logic [1:0]       S_READOUT = READOUT;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] PIX_ONE    = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] BIN_LAST   = {PIX_W{1'b1}};

  logic [1:0]       state_r;
  logic [PIX_W-1:0] clear_idx_r;
  logic [CNT_W-1:0] pix_cnt_r;
  logic             s1_valid_r;
  logic [PIX_W-1:0] s1_addr_r;
  logic             wb_valid_r;
  logic [PIX_W-1:0] wb_addr_r;
  logic [CNT_W-1:0] wb_data_r;
  logic             rd_valid_r;
  logic [PIX_W-1:0] rd_bin_r;

  logic             pix_ready_s;
  logic             accept_s;
  logic             rd_take_s;
  logic             fwd_s;
  logic [CNT_W-1:0] ram_q_s;
  logic [CNT_W-1:0] inc_s;
  logic             we_s;
  logic [PIX_W-1:0] waddr_s;
  logic [CNT_W-1:0] wdata_s;
  logic [PIX_W-1:0] raddr_s;

  assign pix_ready_s = (state_r == S_ACCUM) && (pix_cnt_r < FRAME_LAST);
  assign accept_s    = bus.pix_valid && pix_ready_s;
  assign rd_take_s   = rd_valid_r && bus.rd_ready;
  // The RAM read issued alongside the previous write returned pre-write
  // data, so a same-bin pixel one cycle behind takes the written value.
  assign fwd_s       = wb_valid_r && (wb_addr_r == s1_addr_r);
  assign inc_s       = (fwd_s ? wb_data_r : ram_q_s) + CNT_ONE;

  // Write-port mux: clear sweep in CLEAR, RMW write-back otherwise.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {PIX_W{1'b0}};
    wdata_s = {CNT_W{1'b0}};
    if (state_r == S_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clear_idx_r;
      wdata_s = {CNT_W{1'b0}};
    end else begin
      we_s    = s1_valid_r;
      waddr_s = s1_addr_r;
      wdata_s = inc_s;
    end
  end

  // Read-port mux: pixel bin in ACCUM, current/next bin in READOUT so the
  // output stays stable under backpressure and streams when accepted.
  always_comb begin
    raddr_s = {PIX_W{1'b0}};
    case (state_r)
      S_ACCUM:   raddr_s = bus.pix_data;
      S_READOUT: raddr_s = rd_take_s ? (rd_bin_r + PIX_ONE) : rd_bin_r;
      default:   raddr_s = {PIX_W{1'b0}};
    endcase
  end

  hist_ram #(
    .DEPTH (NUM_BINS),
    .WIDTH (CNT_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (ram_q_s)
  );

  // RMW pipeline: stage 1 (read in flight) and write-back record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= {PIX_W{1'b0}};
      wb_valid_r <= 1'b0;
      wb_addr_r  <= {PIX_W{1'b0}};
      wb_data_r  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_addr_r <= bus.pix_data;
      end
      wb_valid_r <= s1_valid_r;
      wb_addr_r  <= s1_addr_r;
      wb_data_r  <= inc_s;
    end
  end

  // Controller: state, clear sweep, pixel count and readout position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_CLEAR;
      clear_idx_r <= {PIX_W{1'b0}};
      pix_cnt_r   <= {CNT_W{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_bin_r    <= {PIX_W{1'b0}};
    end else begin
      case (state_r)
        S_CLEAR: begin
          clear_idx_r <= clear_idx_r + PIX_ONE;
          if (clear_idx_r == BIN_LAST) begin
            state_r <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (bus.frame_start) begin
            state_r   <= S_ACCUM;
            pix_cnt_r <= {CNT_W{1'b0}};
          end
        end
        S_ACCUM: begin
          // The final write-back lands on the same edge as the exit.
          if (accept_s) begin
            pix_cnt_r <= pix_cnt_r + CNT_ONE;
          end else if (pix_cnt_r == FRAME_LAST) begin
            state_r <= S_READOUT;
          end
        end
        S_READOUT: begin
          // First cycle only issues the bin-0 read; data is valid next.
          if (!rd_valid_r) begin
            rd_valid_r <= 1'b1;
          end else if (rd_take_s) begin
            rd_bin_r <= rd_bin_r + PIX_ONE;
            if (rd_bin_r == BIN_LAST) begin
              rd_valid_r <= 1'b0;
              state_r    <= S_CLEAR;
            end
          end
        end
        default: begin
          state_r <= S_CLEAR;
        end
      endcase
    end
  end

  assign bus.pix_ready = pix_ready_s;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_bin    = rd_bin_r;
  assign bus.rd_count  = rd_valid_r ? ram_q_s : {CNT_W{1'b0}};
  assign bus.busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_gray_histogram.sv
// tb_gray_histogram: directed test of gray_histogram with FRAME_PIXELS=8.
// The bench keeps its own histogram (model[]) built from the pixels it
// sends; a negedge process compares every valid readout bin against it.
module tb_gray_histogram;
  import gray_pkg::*;

  localparam int FP = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_histogram_if #(.CNT_W(CW)) bus ();

  gray_histogram #(.FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int model [256];
  int seen  [256];
  int exp_bin = 0;
  int accepts = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Readout scoreboard: bins must arrive in order with the model's counts.
  always @(negedge clk) begin
    if (chk_en && rst_n && bus.rd_valid) begin
      if (exp_bin < 256) begin
        check("rd_bin", int'(bus.rd_bin), exp_bin);
        check("rd_count", int'(bus.rd_count), model[exp_bin]);
        if (bus.rd_ready) begin
          seen[exp_bin] = int'(bus.rd_count);
          exp_bin++;
          accepts++;
        end
      end else begin
        check("rd_valid_extra", 1, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    foreach (model[i]) model[i] = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_pix_ready", int'(bus.pix_ready), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_rd_bin", int'(bus.rd_bin), 0);
    check("rst_rd_count", int'(bus.rd_count), 0);
    check("rst_busy", int'(bus.busy), 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 400) begin
      tick();
      n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] v, input int gap);
    bus.pix_valid = 1'b1;
    bus.pix_data  = v;
    check("pix_ready_accum", int'(bus.pix_ready), 1);
    model[v]++;
    tick();
    bus.pix_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Called in the cycle after the last accepted pixel (T+1).
  task automatic drain_latency();
    int n;
    n = 1;
    check("pix_ready_full", int'(bus.pix_ready), 0);
    while (!bus.rd_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_rd_valid_latency", n, 3);
  endtask

  task automatic readout(input int stall_a, input int stall_b, input int fs_at);
    int n;
    foreach (seen[i]) seen[i] = -1;
    exp_bin = 0;
    accepts = 0;
    chk_en  = 1'b1;
    n = 0;
    while (!bus.rd_valid && n < 10) begin
      tick();
      n++;
    end
    check("rd_valid_arrives", int'(bus.rd_valid), 1);
    for (int b = 0; b < 256; b++) begin
      if (b == stall_a || b == stall_b) begin
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("stall_rd_valid", int'(bus.rd_valid), 1);
          check("stall_rd_bin", int'(bus.rd_bin), b);
        end
      end
      if (b == fs_at) bus.frame_start = 1'b1;
      bus.rd_ready = 1'b1;
      tick();
      bus.frame_start = 1'b0;
    end
    bus.rd_ready = 1'b0;
    chk_en = 1'b0;
    check("readout_accepts", accepts, 256);
    check("rd_valid_after_last", int'(bus.rd_valid), 0);
    check("busy_after_readout", int'(bus.busy), 1);
  endtask

  task automatic frame_of(input logic [7:0] v);
    clear_model();
    start_frame();
    for (int i = 0; i < FP; i++) send_pix(v, 0);
    drain_latency();
  endtask

  initial begin
    int n;
    logic [7:0] pat [8];
    int gaps [8];
    pat  = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd255, 8'd255, 8'd7, 8'd0};
    gaps = '{1, 2, 3, 1, 2, 3, 1, 0};

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'd0;
    bus.rd_ready    = 1'b0;
    clear_model();

    // Reset and initial clear pass.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    wait_idle(n);
    check("clear_cycles_after_reset", n, 256);

    // 1: eight identical pixels back to back (forwarding).
    frame_of(8'h80);
    check("model_bin128", model[128], 8);
    readout(-1, -1, -1);
    check("s1_bin128", seen[128], 8);
    check("s1_bin127", seen[127], 0);

    // 2: gapped mixed pixels, backpressure at bins 3 and 255.
    wait_idle(n);
    check("clear_cycles_after_readout", n, 256);
    clear_model();
    start_frame();
    for (int i = 0; i < 8; i++) send_pix(pat[i], gaps[i]);
    drain_latency();
    check("model_bin0", model[0], 3);
    readout(3, 255, -1);
    check("s2_bin0", seen[0], 3);
    check("s2_bin1", seen[1], 2);
    check("s2_bin3", seen[3], 0);
    check("s2_bin7", seen[7], 1);
    check("s2_bin255", seen[255], 2);

    // 3: pixels in IDLE and alongside frame_start dropped; frame_start
    //    during READOUT ignored.
    wait_idle(n);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'h44;
    for (int i = 0; i < 3; i++) begin
      check("pix_ready_idle", int'(bus.pix_ready), 0);
      tick();
    end
    clear_model();
    start_frame();
    bus.pix_valid = 1'b0;
    for (int i = 0; i < FP; i++) send_pix(8'h09, 0);
    drain_latency();
    readout(-1, -1, 10);
    check("s3_bin44", seen[8'h44], 0);
    check("s3_bin9", seen[9], 8);
    wait_idle(n);
    check("clear_cycles_s3", n, 256);

    // 4: reset mid-frame.
    clear_model();
    start_frame();
    for (int i = 0; i < 4; i++) send_pix(8'h10, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_vals();
    wait_idle(n);
    check("clear_cycles_after_abort", n, 256);
    frame_of(8'h20);
    readout(-1, -1, -1);
    check("s4_bin16", seen[16], 0);
    check("s4_bin32", seen[32], 8);

    // 5: back-to-back frames prove the auto-clear.
    wait_idle(n);
    frame_of(8'h05);
    readout(-1, -1, -1);
    check("s5a_bin5", seen[5], 8);
    wait_idle(n);
    frame_of(8'h06);
    readout(-1, -1, -1);
    check("s5b_bin5", seen[5], 0);
    check("s5b_bin6", seen[6], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
